// File: rtl/program_loader.sv
// program_loader: loads a program of up to 32 six-bit instruction words over a
// valid/ready port into a register file, then releases the CPU via CpuRun.
// Fetch side reads combinationally by addr; unloaded locations read as zero.
// Optional feature: define LOADER_BOOTROM_EN to preload a fixed program on
// reset and come out of reset directly in RUN.
module program_loader (
  input  logic       clk,
  input  logic       Reset,
  input  logic       Start,
  input  logic [5:0] LdData,
  input  logic       LdValid,
  input  logic       LdLast,
  output logic       LdReady,
  input  logic [4:0] addr,
  output logic [5:0] InsOut,
  output logic       CpuRun,
  output logic [5:0] WordCnt
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t     state;
  logic [5:0] mem [32];
  logic       wr_en;

`ifdef LOADER_BOOTROM_EN
  localparam logic [5:0] BOOT_ROM [32] = '{
    6'h01, 6'h12, 6'h23, 6'h34, 6'h05, 6'h16, 6'h27, 6'h38,
    6'h09, 6'h1A, 6'h2B, 6'h3C, 6'h0D, 6'h1E, 6'h2F, 6'h30,
    6'h11, 6'h22, 6'h33, 6'h04, 6'h15, 6'h26, 6'h37, 6'h08,
    6'h19, 6'h2A, 6'h3B, 6'h0C, 6'h1D, 6'h2E, 6'h3F, 6'h00
  };
`endif

  // Handshake: a word is taken only while loading and ready.
  always_comb begin
    wr_en = (state == LOAD) && LdReady && LdValid;
  end

  // Control FSM with registered LdReady/CpuRun and word counter.
  always_ff @(posedge clk) begin
    if (Reset) begin
`ifdef LOADER_BOOTROM_EN
      state   <= RUN;
      WordCnt <= 6'd32;
      LdReady <= 1'b0;
      CpuRun  <= 1'b1;
`else
      state   <= IDLE;
      WordCnt <= '0;
      LdReady <= 1'b0;
      CpuRun  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            state   <= LOAD;
            WordCnt <= '0;
            LdReady <= 1'b1;
          end
        end
        LOAD: begin
          if (wr_en) begin
            WordCnt <= WordCnt + 6'd1;
            // Word 32 ends the load even without LdLast so the count never wraps.
            if (LdLast || (WordCnt == 6'd31)) begin
              state   <= RUN;
              LdReady <= 1'b0;
              CpuRun  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (Start) begin
            state   <= LOAD;
            WordCnt <= '0;
            LdReady <= 1'b1;
            CpuRun  <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          WordCnt <= '0;
          LdReady <= 1'b0;
          CpuRun  <= 1'b0;
        end
      endcase
    end
  end

  // Program storage: cleared (or preloaded) on reset, written on handshake.
  always_ff @(posedge clk) begin
    if (Reset) begin
      for (int unsigned i = 0; i < 32; i++) begin
`ifdef LOADER_BOOTROM_EN
        mem[i] <= BOOT_ROM[i];
`else
        mem[i] <= '0;
`endif
      end
    end else if (wr_en) begin
      mem[WordCnt[4:0]] <= LdData;
    end
  end

  // Fetch port: locations at or beyond the loaded length read as zero.
  always_comb begin
    InsOut = '0;
    if ({1'b0, addr} < WordCnt) begin
      InsOut = mem[addr];
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: table-driven load/read vectors plus
// hand-written sequences for reload, 32-word overflow and mid-load reset.
module tb_program_loader;

  logic       clk = 1'b0;
  logic       Reset, Start, LdValid, LdLast;
  logic [5:0] LdData;
  logic [4:0] addr;
  logic       LdReady, CpuRun;
  logic [5:0] InsOut, WordCnt;

  int n_cmp = 0;
  int n_err = 0;

  program_loader dut (
    .clk     (clk),
    .Reset   (Reset),
    .Start   (Start),
    .LdData  (LdData),
    .LdValid (LdValid),
    .LdLast  (LdLast),
    .LdReady (LdReady),
    .addr    (addr),
    .InsOut  (InsOut),
    .CpuRun  (CpuRun),
    .WordCnt (WordCnt)
  );

  always #5 clk = ~clk;

`ifdef LOADER_BOOTROM_EN
  localparam logic [5:0] BOOT [32] = '{
    6'h01, 6'h12, 6'h23, 6'h34, 6'h05, 6'h16, 6'h27, 6'h38,
    6'h09, 6'h1A, 6'h2B, 6'h3C, 6'h0D, 6'h1E, 6'h2F, 6'h30,
    6'h11, 6'h22, 6'h33, 6'h04, 6'h15, 6'h26, 6'h37, 6'h08,
    6'h19, 6'h2A, 6'h3B, 6'h0C, 6'h1D, 6'h2E, 6'h3F, 6'h00
  };
  localparam logic [5:0] RST_CNT = 6'd32;
  localparam logic       RST_RUN = 1'b1;
  function automatic logic [5:0] rst_mem(input int i);
    return BOOT[i];
  endfunction
`else
  localparam logic [5:0] RST_CNT = 6'd0;
  localparam logic       RST_RUN = 1'b0;
  function automatic logic [5:0] rst_mem(input int i);
    return (i >= 0) ? 6'h00 : 6'h00;
  endfunction
`endif

  typedef struct {
    logic [5:0] data;
    logic       valid;
    logic       last;
    logic [5:0] cnt;
    logic       run;
  } ld_vec_t;

  typedef struct {
    logic [4:0] a;
    logic [5:0] d;
  } rd_vec_t;

  ld_vec_t lv [9];
  rd_vec_t rv [11];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_chk(input string name, input logic [4:0] a, input logic [5:0] exp);
    addr = a;
    #1;
    check($sformatf("%s addr%0d", name, a), 8'(InsOut), 8'(exp));
  endtask

  task automatic check_state(input string name, input logic rdy, input logic run,
                             input logic [5:0] cnt);
    check({name, " LdReady"}, 8'(LdReady), 8'(rdy));
    check({name, " CpuRun"},  8'(CpuRun),  8'(run));
    check({name, " WordCnt"}, 8'(WordCnt), 8'(cnt));
  endtask

  task automatic do_start(input string name);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    check_state({name, " start"}, 1'b1, 1'b0, 6'd0);
  endtask

  task automatic apply_load(input int first, input int last_idx);
    for (int k = first; k <= last_idx; k++) begin
      LdData  = lv[k].data;
      LdValid = lv[k].valid;
      LdLast  = lv[k].last;
      tick();
      check_state($sformatf("load[%0d]", k), !lv[k].run, lv[k].run, lv[k].cnt);
      if (lv[k].valid) read_chk($sformatf("load[%0d] visible", k), 5'(lv[k].cnt - 6'd1), lv[k].data);
    end
    LdValid = 1'b0;
    LdLast  = 1'b0;
  endtask

  task automatic apply_read(input int first, input int last_idx);
    for (int k = first; k <= last_idx; k++) begin
      read_chk($sformatf("read[%0d]", k), rv[k].a, rv[k].d);
    end
  endtask

  task automatic check_reset_image(input string name);
    check_state(name, 1'b0, RST_RUN, RST_CNT);
    for (int i = 0; i < 32; i++) read_chk(name, 5'(i), rst_mem(i));
  endtask

  initial begin
    // Load vectors: {data, valid, last, WordCnt after, CpuRun after}
    lv[0] = '{6'h11, 1'b1, 1'b0, 6'd1, 1'b0};
    lv[1] = '{6'h22, 1'b1, 1'b0, 6'd2, 1'b0};
    lv[2] = '{6'h05, 1'b1, 1'b1, 6'd3, 1'b1};
    lv[3] = '{6'h0A, 1'b1, 1'b0, 6'd1, 1'b0};
    lv[4] = '{6'h3C, 1'b0, 1'b0, 6'd1, 1'b0};
    lv[5] = '{6'h0B, 1'b1, 1'b0, 6'd2, 1'b0};
    lv[6] = '{6'h2F, 1'b0, 1'b1, 6'd2, 1'b0};
    lv[7] = '{6'h0C, 1'b1, 1'b1, 6'd3, 1'b1};
    lv[8] = '{6'h3F, 1'b1, 1'b1, 6'd1, 1'b1};
    // Read vectors: {addr, expected InsOut}
    rv[0]  = '{5'd0,  6'h11};
    rv[1]  = '{5'd1,  6'h22};
    rv[2]  = '{5'd2,  6'h05};
    rv[3]  = '{5'd3,  6'h00};
    rv[4]  = '{5'd31, 6'h00};
    rv[5]  = '{5'd0,  6'h0A};
    rv[6]  = '{5'd1,  6'h0B};
    rv[7]  = '{5'd2,  6'h0C};
    rv[8]  = '{5'd3,  6'h00};
    rv[9]  = '{5'd0,  6'h3F};
    rv[10] = '{5'd1,  6'h00};

    Reset = 1'b1; Start = 1'b0; LdValid = 1'b0; LdLast = 1'b0;
    LdData = '0; addr = '0;
    tick();
    tick();
    Reset = 1'b0;
    check_reset_image("reset");
    tick();
    check("post-reset CpuRun", 8'(CpuRun), 8'(RST_RUN));

    // LdValid outside LOAD must not write or count
    LdValid = 1'b1; LdData = 6'h2A;
    tick();
    LdValid = 1'b0;
    check("idle valid WordCnt", 8'(WordCnt), 8'(RST_CNT));
    read_chk("idle valid", 5'd0, rst_mem(0));

    // Three back-to-back words
    do_start("A");
    apply_load(0, 2);
    apply_read(0, 4);

    // LdValid in RUN ignored
    LdValid = 1'b1; LdData = 6'h15;
    tick();
    LdValid = 1'b0;
    check_state("run valid", 1'b0, 1'b1, 6'd3);
    read_chk("run valid", 5'd3, 6'h00);

    // Reload from RUN with gapped LdValid
    do_start("B");
    apply_load(3, 7);
    apply_read(5, 8);

    // Reload with single word 0x3F
    do_start("C");
    apply_load(8, 8);
    apply_read(9, 10);

    // 32 words without LdLast, Start during LOAD ignored, 33rd word ignored
    do_start("D");
    for (int i = 0; i < 32; i++) begin
      LdData  = 6'((i * 7 + 3) & 63);
      LdValid = 1'b1;
      LdLast  = 1'b0;
      Start   = (i == 10);
      tick();
      Start = 1'b0;
      check($sformatf("full WordCnt[%0d]", i), 8'(WordCnt), 8'(i + 1));
      check($sformatf("full CpuRun[%0d]", i), 8'(CpuRun), 8'(i == 31));
    end
    LdData = 6'h3E;
    tick();
    LdValid = 1'b0;
    check_state("33rd word", 1'b0, 1'b1, 6'd32);
    for (int i = 0; i < 32; i++) read_chk("full", 5'(i), 6'((i * 7 + 3) & 63));

    // Reset after 2 of 5 words discards the partial program
    do_start("E");
    LdValid = 1'b1;
    LdData = 6'h21; tick();
    LdData = 6'h22; tick();
    check("partial WordCnt", 8'(WordCnt), 8'd2);
    LdData = 6'h23; Reset = 1'b1;
    tick();
    Reset = 1'b0; LdValid = 1'b0;
    check_reset_image("midload reset");

    // Start together with Reset yields the reset state
    Start = 1'b1; Reset = 1'b1;
    tick();
    Start = 1'b0; Reset = 1'b0;
    check_state("start+reset", 1'b0, RST_RUN, RST_CNT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
